// File: rtl/hamming_stream_ctrl.sv
// Serial Hamming(7,4) decoder controller: bit-stream assembly, syndrome/correct, output FIFO.
// Optional statistics counters are built only when HAMMING_ERR_STATS_EN is defined.
module hamming_stream_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_bit,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [3:0]       m_data,
    output logic [2:0]       m_syn,
    output logic             m_err,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] cw_count,
    output logic [CNT_W-1:0] corr_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [0:0] ST_ASSEMBLE = 1'b0;
    localparam logic [0:0] ST_DECODE   = 1'b1;

    logic [0:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_cw;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [7:0]       r_last;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic [2:0] w_syn;
    logic       w_err;
    logic [6:0] w_mask;
    logic [6:0] w_fix;
    logic [3:0] w_data;
    logic [7:0] w_entry;
    logic [7:0] w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_accept;

    assign w_syn = {r_cw[6] ^ r_cw[5] ^ r_cw[4] ^ r_cw[3],
                    r_cw[6] ^ r_cw[5] ^ r_cw[2] ^ r_cw[1],
                    r_cw[6] ^ r_cw[4] ^ r_cw[2] ^ r_cw[0]};
    assign w_err = (w_syn != 3'b000);

    // Only data-bit syndromes need a fix; parity-bit errors do not touch the nibble.
    always_comb begin
        w_mask = 7'b0000000;
        case (w_syn)
            3'b111:  w_mask = 7'b1000000;
            3'b110:  w_mask = 7'b0100000;
            3'b101:  w_mask = 7'b0010000;
            3'b011:  w_mask = 7'b0000100;
            default: w_mask = 7'b0000000;
        endcase
    end

    assign w_fix    = r_cw ^ w_mask;
    assign w_data   = {w_fix[2], w_fix[4], w_fix[5], w_fix[6]};
    assign w_entry  = {w_data, w_syn, w_err};

    assign w_full   = (r_count == FIFO_DEPTH[PTR_W:0]);
    assign w_empty  = (r_count == '0);
    assign w_push   = (r_state == ST_DECODE) && !w_full;
    assign w_pop    = !w_empty && m_ready;
    assign s_ready  = rst_n && (r_state == ST_ASSEMBLE);
    assign w_accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ASSEMBLE;
            r_bit_cnt <= 3'd0;
            r_cw      <= 7'd0;
        end else if (r_state == ST_ASSEMBLE) begin
            if (w_accept) begin
                r_cw[r_bit_cnt] <= s_bit;
                if (r_bit_cnt == 3'd6) begin
                    r_bit_cnt <= 3'd0;
                    r_state   <= ST_DECODE;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end else if (w_push) begin
            r_state <= ST_ASSEMBLE;
        end
    end

    // Full is the registered count, so a same-cycle pop frees space only from the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= 8'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign m_data  = w_head[7:4];
    assign m_syn   = w_head[3:1];
    assign m_err   = w_head[0];
    assign m_valid = !w_empty;

`ifdef HAMMING_ERR_STATS_EN
    logic [CNT_W-1:0] r_cw_count;
    logic [CNT_W-1:0] r_corr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cw_count   <= '0;
            r_corr_count <= '0;
        end else if (clr) begin
            r_cw_count   <= '0;
            r_corr_count <= '0;
        end else if (w_push) begin
            if (r_cw_count != {CNT_W{1'b1}})
                r_cw_count <= r_cw_count + CNT_W'(1);
            if (w_err && (r_corr_count != {CNT_W{1'b1}}))
                r_corr_count <= r_corr_count + CNT_W'(1);
        end
    end

    assign cw_count   = r_cw_count;
    assign corr_count = r_corr_count;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr;
    assign cw_count     = '0;
    assign corr_count   = '0;
`endif

endmodule
